// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full adder stepped over W cycles, LSB first,
// with valid/ready handshakes on the request and result sides.

module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);

    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_a & i_ci) | (i_b & i_ci);

endmodule

module serial_add_ctrl #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_a,
    input  logic [W-1:0] s_b,
    input  logic         s_cin,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_sum,
    output logic         m_cout,
    output logic         busy
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] CntLast = CW'(W - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]    r_state;
    logic [W-1:0]  r_op_a;
    logic [W-1:0]  r_op_b;
    logic          r_carry;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_shift;
    logic [W-1:0]  r_m_sum;
    logic          r_m_cout;

    logic          w_fa_s;
    logic          w_fa_co;
    logic [W-1:0]  w_shift_next;

    full_adder u_fa (
        .i_a  (r_op_a[0]),
        .i_b  (r_op_b[0]),
        .i_ci (r_carry),
        .o_s  (w_fa_s),
        .o_co (w_fa_co)
    );

    // Sum bits enter at the MSB so that after W shifts bit 0 sits at index 0.
    always_comb begin
        w_shift_next        = r_shift >> 1;
        w_shift_next[W-1]   = w_fa_s;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state  <= StIdle;
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            r_shift  <= '0;
            r_m_sum  <= '0;
            r_m_cout <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (s_valid) begin
                        r_op_a  <= s_a;
                        r_op_b  <= s_b;
                        r_carry <= s_cin;
                        r_cnt   <= '0;
                        r_shift <= '0;
                        r_state <= StRun;
                    end
                end
                StRun: begin
                    r_op_a  <= r_op_a >> 1;
                    r_op_b  <= r_op_b >> 1;
                    r_carry <= w_fa_co;
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt + CW'(1);
                    if (r_cnt == CntLast) begin
                        r_m_sum  <= w_shift_next;
                        r_m_cout <= w_fa_co;
                        r_state  <= StDone;
                    end
                end
                StDone: begin
                    if (m_ready) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign s_ready = (r_state == StIdle);
    assign m_valid = (r_state == StDone);
    assign busy    = (r_state == StRun);
    assign m_sum   = r_m_sum;
    assign m_cout  = r_m_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl: W=8 main instance plus W=1 and W=13 builds.

module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rstn;

    logic       s_valid, s_ready, s_cin, m_valid, m_ready, m_cout, busy;
    logic [7:0] s_a, s_b, m_sum;

    logic       u1_s_valid, u1_s_ready, u1_s_cin, u1_m_valid, u1_m_ready, u1_m_cout, u1_busy;
    logic [0:0] u1_s_a, u1_s_b, u1_m_sum;

    logic        u13_s_valid, u13_s_ready, u13_s_cin, u13_m_valid, u13_m_ready, u13_m_cout;
    logic        u13_busy;
    logic [12:0] u13_s_a, u13_s_b, u13_m_sum;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.W(8)) u_dut8 (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b),
        .s_cin(s_cin), .m_valid(m_valid), .m_ready(m_ready), .m_sum(m_sum), .m_cout(m_cout),
        .busy(busy)
    );

    serial_add_ctrl #(.W(1)) u_dut1 (
        .clk(clk), .rstn(rstn), .s_valid(u1_s_valid), .s_ready(u1_s_ready), .s_a(u1_s_a),
        .s_b(u1_s_b), .s_cin(u1_s_cin), .m_valid(u1_m_valid), .m_ready(u1_m_ready),
        .m_sum(u1_m_sum), .m_cout(u1_m_cout), .busy(u1_busy)
    );

    serial_add_ctrl #(.W(13)) u_dut13 (
        .clk(clk), .rstn(rstn), .s_valid(u13_s_valid), .s_ready(u13_s_ready), .s_a(u13_s_a),
        .s_b(u13_s_b), .s_cin(u13_s_cin), .m_valid(u13_m_valid), .m_ready(u13_m_ready),
        .m_sum(u13_m_sum), .m_cout(u13_m_cout), .busy(u13_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for m_valid on the W=8 instance; counts edges and busy samples.
    task automatic wait_valid8(output int lat, output int bcnt);
        lat  = 0;
        bcnt = 0;
        while (!m_valid && lat < 40) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        step();
        step();
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        checks++; if (m_sum !== 8'h00) begin errors++; $display("FAIL reset_m_sum got %h want 00", m_sum); end
        checks++; if (m_cout !== 1'b0) begin errors++; $display("FAIL reset_m_cout got %b want 0", m_cout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (u13_s_ready !== 1'b1) begin errors++; $display("FAIL reset_w13_s_ready got %b want 1", u13_s_ready); end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int lat, bcnt;
        s_a = 8'h35; s_b = 8'h4A; s_cin = 1'b0; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL basic_s_ready_run got %b want 0", s_ready); end
        wait_valid8(lat, bcnt);
        checks++; if (lat !== 8) begin errors++; $display("FAIL basic_latency got %0d want 8", lat); end
        checks++; if (bcnt !== 8) begin errors++; $display("FAIL basic_busy_cycles got %0d want 8", bcnt); end
        checks++; if (m_sum !== 8'h7F) begin errors++; $display("FAIL basic_sum got %h want 7f", m_sum); end
        checks++; if (m_cout !== 1'b0) begin errors++; $display("FAIL basic_cout got %b want 0", m_cout); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_done got %b want 0", busy); end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b want 0", m_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL basic_s_ready_idle got %b want 1", s_ready); end
    endtask

    task automatic test_carry();
        int lat, bcnt;
        s_a = 8'hFF; s_b = 8'h01; s_cin = 1'b0; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        wait_valid8(lat, bcnt);
        checks++; if (m_sum !== 8'h00) begin errors++; $display("FAIL carry1_sum got %h want 00", m_sum); end
        checks++; if (m_cout !== 1'b1) begin errors++; $display("FAIL carry1_cout got %b want 1", m_cout); end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        s_a = 8'hFF; s_b = 8'hFF; s_cin = 1'b1; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        wait_valid8(lat, bcnt);
        checks++; if (m_sum !== 8'hFF) begin errors++; $display("FAIL carry2_sum got %h want ff", m_sum); end
        checks++; if (m_cout !== 1'b1) begin errors++; $display("FAIL carry2_cout got %b want 1", m_cout); end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat, bcnt;
        s_a = 8'h12; s_b = 8'h34; s_cin = 1'b0; s_valid = 1'b1;
        step();
        // Pending request held throughout the op and the stall.
        s_a = 8'h01; s_b = 8'h01; s_cin = 1'b0;
        wait_valid8(lat, bcnt);
        for (int i = 0; i < 5; i++) begin
            checks++; if (m_sum !== 8'h46 || m_cout !== 1'b0) begin
                errors++; $display("FAIL bp_hold_result cyc %0d got %h/%b want 46/0", i, m_sum, m_cout);
            end
            checks++; if (s_ready !== 1'b0 || m_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold_hs cyc %0d got rdy %b vld %b want 0 1", i, s_ready, m_valid);
            end
            step();
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        checks++; if (s_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL bp_bubble got rdy %b busy %b want 1 0", s_ready, busy);
        end
        step();
        s_valid = 1'b0;
        checks++; if (busy !== 1'b1 || s_ready !== 1'b0) begin
            errors++; $display("FAIL bp_accept got busy %b rdy %b want 1 0", busy, s_ready);
        end
        wait_valid8(lat, bcnt);
        checks++; if (m_sum !== 8'h02) begin errors++; $display("FAIL bp_second_sum got %h want 02", m_sum); end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    task automatic test_input_change();
        int lat, bcnt;
        s_a = 8'h10; s_b = 8'h20; s_cin = 1'b0; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        step();
        step();
        s_a = 8'h00; s_cin = 1'b1;
        wait_valid8(lat, bcnt);
        checks++; if (m_sum !== 8'h30) begin errors++; $display("FAIL inchg_sum got %h want 30", m_sum); end
        checks++; if (m_cout !== 1'b0) begin errors++; $display("FAIL inchg_cout got %b want 0", m_cout); end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat, bcnt;
        s_a = 8'h55; s_b = 8'h66; s_cin = 1'b0; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        step();
        step();
        rstn = 1'b0;
        step();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b want 0", m_valid); end
        checks++; if (m_sum !== 8'h00) begin errors++; $display("FAIL rstmid_sum got %h want 00", m_sum); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b want 0", busy); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rstmid_s_ready got %b want 1", s_ready); end
        rstn = 1'b1;
        step();
        s_a = 8'h01; s_b = 8'h02; s_cin = 1'b0; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        wait_valid8(lat, bcnt);
        checks++; if (lat !== 8) begin errors++; $display("FAIL rstmid_latency got %0d want 8", lat); end
        checks++; if (m_sum !== 8'h03 || m_cout !== 1'b0) begin
            errors++; $display("FAIL rstmid_fresh got %h/%b want 03/0", m_sum, m_cout);
        end
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
    endtask

    task automatic test_w1();
        u1_s_a = 1'b1; u1_s_b = 1'b1; u1_s_cin = 1'b1; u1_s_valid = 1'b1;
        step();
        u1_s_valid = 1'b0;
        checks++; if (u1_busy !== 1'b1 || u1_m_valid !== 1'b0) begin
            errors++; $display("FAIL w1_run got busy %b vld %b want 1 0", u1_busy, u1_m_valid);
        end
        step();
        checks++; if (u1_m_valid !== 1'b1) begin errors++; $display("FAIL w1_valid got %b want 1", u1_m_valid); end
        checks++; if (u1_m_sum !== 1'b1 || u1_m_cout !== 1'b1) begin
            errors++; $display("FAIL w1_111 got %b/%b want 1/1", u1_m_sum, u1_m_cout);
        end
        u1_m_ready = 1'b1;
        step();
        u1_m_ready = 1'b0;
        u1_s_a = 1'b0; u1_s_b = 1'b0; u1_s_cin = 1'b0; u1_s_valid = 1'b1;
        step();
        u1_s_valid = 1'b0;
        step();
        checks++; if (u1_m_valid !== 1'b1 || u1_m_sum !== 1'b0 || u1_m_cout !== 1'b0) begin
            errors++; $display("FAIL w1_000 got vld %b %b/%b want 1 0/0", u1_m_valid, u1_m_sum, u1_m_cout);
        end
        u1_m_ready = 1'b1;
        step();
        u1_m_ready = 1'b0;
    endtask

    task automatic test_random_w13();
        logic [12:0] ra, rb;
        logic        rc;
        logic [13:0] exp;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            ra  = 13'($urandom);
            rb  = 13'($urandom);
            rc  = 1'($urandom);
            exp = {1'b0, ra} + {1'b0, rb} + 14'(rc);
            repeat ($urandom_range(0, 3)) step();
            u13_s_a = ra; u13_s_b = rb; u13_s_cin = rc; u13_s_valid = 1'b1;
            step();
            u13_s_valid = 1'b0;
            u13_s_a = ~ra;
            lat = 0;
            while (!u13_m_valid && lat < 40) begin
                step();
                lat++;
            end
            checks++; if (lat !== 13) begin errors++; $display("FAIL rnd_latency op %0d got %0d want 13", i, lat); end
            repeat ($urandom_range(0, 3)) step();
            checks++; if (u13_m_valid !== 1'b1 || {u13_m_cout, u13_m_sum} !== exp) begin
                errors++;
                $display("FAIL rnd_result op %0d got vld %b %b/%h want 1 %b/%h", i, u13_m_valid,
                         u13_m_cout, u13_m_sum, exp[13], exp[12:0]);
            end
            u13_m_ready = 1'b1;
            step();
            u13_m_ready = 1'b0;
            checks++; if (u13_m_valid !== 1'b0) begin
                errors++; $display("FAIL rnd_dup op %0d got vld %b want 0", i, u13_m_valid);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        s_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; m_ready = 1'b0;
        u1_s_valid = 1'b0; u1_s_a = '0; u1_s_b = '0; u1_s_cin = 1'b0; u1_m_ready = 1'b0;
        u13_s_valid = 1'b0; u13_s_a = '0; u13_s_b = '0; u13_s_cin = 1'b0; u13_m_ready = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_input_change();
        test_reset_mid();
        test_w1();
        test_random_w13();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
